// File: rtl/video_mnist_pkg.sv
// Shared types for the MNIST video front end: scheduler FSM states and the
// AXI4-Stream sideband bit that marks start of frame.
package video_mnist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PASS,
    ST_DROP
  } sched_state_e;

  localparam int unsigned SOF_BIT = 0;

endpackage

// File: rtl/video_frame_line_counter.sv
// Counts tlast beats within a frame; reports frame end and whether the frame
// has started (any line or pixel consumed), which marks a SOF as early.
module video_frame_line_counter #(
  parameter int unsigned IMG_Y_NUM   = 480,
  parameter int unsigned IMG_Y_WIDTH = 10
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic beat_i,
  input  logic start_i,
  input  logic clr_i,
  input  logic tlast_i,
  output logic line_busy_o,
  output logic frame_end_o
);

  localparam logic [IMG_Y_WIDTH-1:0] LAST_LINE = IMG_Y_WIDTH'(IMG_Y_NUM - 1);

  logic [IMG_Y_WIDTH-1:0] line_q;
  logic                   mid_q;

  always_comb begin
    line_busy_o = (line_q != '0) || mid_q;
    frame_end_o = beat_i && !start_i && tlast_i && (line_q == LAST_LINE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      line_q <= '0;
      mid_q  <= 1'b0;
    end else if (beat_i && start_i) begin
      // the SOF beat is itself the first pixel of the new frame
      line_q <= tlast_i ? IMG_Y_WIDTH'(1) : '0;
      mid_q  <= !tlast_i;
    end else if (clr_i) begin
      line_q <= '0;
      mid_q  <= 1'b0;
    end else if (beat_i) begin
      if (tlast_i) begin
        line_q <= (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
        mid_q  <= 1'b0;
      end else begin
        mid_q  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_mnist_frame_scheduler.sv
// Frame scheduler in front of the MNIST CNN core: per-frame pass/drop
// decimation, frame-stable blank parameter and pass/drop/error statistics.
module video_mnist_frame_scheduler
  import video_mnist_pkg::*;
#(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TDATA_WIDTH   = 1,
  parameter int unsigned IMG_Y_NUM     = 480,
  parameter int unsigned IMG_Y_WIDTH   = 10,
  parameter int unsigned SKIP_WIDTH    = 4,
  parameter int unsigned BLANK_Y_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     ctl_enable,
  input  logic [SKIP_WIDTH-1:0]    ctl_skip,
  input  logic [BLANK_Y_WIDTH-1:0] ctl_blank_num,
  output logic [BLANK_Y_WIDTH-1:0] param_blank_num,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [CNT_WIDTH-1:0]     stat_pass_count,
  output logic [CNT_WIDTH-1:0]     stat_drop_count,
  output logic                     stat_sof_error,
  output logic                     stat_busy
);

  sched_state_e             state_q;
  logic [SKIP_WIDTH-1:0]    phase_q, skip_q, skip_d;
  logic [BLANK_Y_WIDTH-1:0] blank_q;
  logic [CNT_WIDTH-1:0]     pass_cnt_q, drop_cnt_q;
  logic                     sof_err_q, busy_q;

  logic sof_c, in_frame_c, early_c, decide_c, new_pass_c, fwd_c, hs_c;
  logic line_busy, frame_end;

  always_comb begin
    sof_c      = s_axi4s_tvalid && s_axi4s_tuser[SOF_BIT];
    in_frame_c = (state_q == ST_PASS) || (state_q == ST_DROP);
    early_c    = in_frame_c && sof_c && line_busy;
    decide_c   = ctl_enable && sof_c && ((state_q == ST_SYNC) || early_c);
    new_pass_c = (phase_q == '0);
    skip_d     = decide_c ? ctl_skip : skip_q;
    // a SOF beat that opens a passed frame is forwarded on the decision cycle
    unique case (state_q)
      ST_SYNC:          fwd_c = decide_c && new_pass_c;
      ST_PASS, ST_DROP: fwd_c = early_c ? (decide_c && new_pass_c) : (state_q == ST_PASS);
      default:          fwd_c = 1'b0;
    endcase
    m_axi4s_tvalid = s_axi4s_tvalid && fwd_c;
    s_axi4s_tready = fwd_c ? m_axi4s_tready : 1'b1;
    hs_c           = s_axi4s_tvalid && s_axi4s_tready;
  end

  always_comb begin
    m_axi4s_tuser   = s_axi4s_tuser;
    m_axi4s_tlast   = s_axi4s_tlast;
    m_axi4s_tdata   = s_axi4s_tdata;
    param_blank_num = blank_q;
    stat_pass_count = pass_cnt_q;
    stat_drop_count = drop_cnt_q;
    stat_sof_error  = sof_err_q;
    stat_busy       = busy_q;
  end

  video_frame_line_counter #(
    .IMG_Y_NUM   (IMG_Y_NUM),
    .IMG_Y_WIDTH (IMG_Y_WIDTH)
  ) u_line_cnt (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .beat_i      (hs_c && (in_frame_c || decide_c)),
    .start_i     (decide_c),
    .clr_i       (!in_frame_c),
    .tlast_i     (s_axi4s_tlast),
    .line_busy_o (line_busy),
    .frame_end_o (frame_end)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      skip_q     <= '0;
      blank_q    <= '0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
      sof_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (hs_c && early_c) sof_err_q <= 1'b1;
      if (hs_c && decide_c) begin
        skip_q  <= skip_d;
        blank_q <= ctl_blank_num;
        phase_q <= (phase_q == skip_d) ? '0 : phase_q + 1'b1;
        busy_q  <= 1'b1;
        if (new_pass_c) begin
          state_q    <= ST_PASS;
          pass_cnt_q <= pass_cnt_q + 1'b1;
        end else begin
          state_q    <= ST_DROP;
          drop_cnt_q <= drop_cnt_q + 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: if (ctl_enable) state_q <= ST_SYNC;
          ST_SYNC: if (!ctl_enable) state_q <= ST_IDLE;
          ST_PASS, ST_DROP: begin
            // an early SOF while disabled abandons the frame without a decision
            if (hs_c && (early_c || frame_end)) begin
              state_q <= ctl_enable ? ST_SYNC : ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_mnist_frame_scheduler.sv
// Scoreboard bench for the frame scheduler: 4-line frames of 8 pixels, pixel
// data tagged with frame id and beat index.
module tb_video_mnist_frame_scheduler;

  localparam int unsigned BEATS = 32;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        ctl_enable;
  logic [3:0]  ctl_skip;
  logic [7:0]  ctl_blank_num;
  logic [7:0]  param_blank_num;
  logic [0:0]  s_axi4s_tuser;
  logic        s_axi4s_tlast;
  logic [15:0] s_axi4s_tdata;
  logic        s_axi4s_tvalid;
  logic        s_axi4s_tready;
  logic [0:0]  m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [15:0] m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready;
  logic [15:0] stat_pass_count;
  logic [15:0] stat_drop_count;
  logic        stat_sof_error;
  logic        stat_busy;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q[$];
  logic [3:0]  m_phase = '0;
  bit          cur_fwd = 1'b0;
  bit          bp_en   = 1'b0;

  video_mnist_frame_scheduler #(
    .TUSER_WIDTH   (1),
    .TDATA_WIDTH   (16),
    .IMG_Y_NUM     (4),
    .IMG_Y_WIDTH   (3),
    .SKIP_WIDTH    (4),
    .BLANK_Y_WIDTH (8),
    .CNT_WIDTH     (16)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .ctl_enable      (ctl_enable),
    .ctl_skip        (ctl_skip),
    .ctl_blank_num   (ctl_blank_num),
    .param_blank_num (param_blank_num),
    .s_axi4s_tuser   (s_axi4s_tuser),
    .s_axi4s_tlast   (s_axi4s_tlast),
    .s_axi4s_tdata   (s_axi4s_tdata),
    .s_axi4s_tvalid  (s_axi4s_tvalid),
    .s_axi4s_tready  (s_axi4s_tready),
    .m_axi4s_tuser   (m_axi4s_tuser),
    .m_axi4s_tlast   (m_axi4s_tlast),
    .m_axi4s_tdata   (m_axi4s_tdata),
    .m_axi4s_tvalid  (m_axi4s_tvalid),
    .m_axi4s_tready  (m_axi4s_tready),
    .stat_pass_count (stat_pass_count),
    .stat_drop_count (stat_drop_count),
    .stat_sof_error  (stat_sof_error),
    .stat_busy       (stat_busy)
  );

  initial forever #5 aclk = ~aclk;

  initial begin
    m_axi4s_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axi4s_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every handshake, checks stall hold.
  initial begin
    logic        prev_stall;
    logic [17:0] prev_beat, got, exp;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge aclk);
      got = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
      if (aresetn !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_axi4s_tvalid !== 1'b1 || got !== prev_beat) begin
            errors++;
            $display("FAIL tvalid_hold: valid=%b beat=%h required valid=1 beat=%h", m_axi4s_tvalid, got, prev_beat);
          end
        end
        if (m_axi4s_tvalid === 1'b1 && m_axi4s_tready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h, none expected", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL out_beat: got %h required %h", got, exp);
            end
          end
        end
        prev_stall = (m_axi4s_tvalid === 1'b1) && (m_axi4s_tready !== 1'b1);
        prev_beat  = got;
      end
    end
  end

  function automatic bit model_decide();
    bit pass;
    pass    = (m_phase == 4'd0);
    m_phase = (m_phase == ctl_skip) ? 4'd0 : m_phase + 4'd1;
    return pass;
  endfunction

  task automatic send_beat(input logic u, input logic l, input logic [15:0] d, input bit fwd);
    bit got;
    got            = 1'b0;
    s_axi4s_tuser  = u;
    s_axi4s_tlast  = l;
    s_axi4s_tdata  = d;
    s_axi4s_tvalid = 1'b1;
    if (fwd) exp_q.push_back({u, l, d});
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge aclk);
      if (c == 0 && !fwd) begin
        checks++;
        if (s_axi4s_tready !== 1'b1) begin
          errors++;
          $display("FAIL discard_tready: beat %h s_tready=%b required 1", d, s_axi4s_tready);
        end
      end
      got = (s_axi4s_tready === 1'b1);
      @(posedge aclk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %h never accepted, required accept within 200 cycles", d);
    end
  endtask

  // Beats b0..b1-1 of frame fid; the model decides pass/drop at beat 0.
  task automatic send_frame(input int fid, input int b0, input int b1, input bit model);
    for (int b = b0; b < b1; b++) begin
      if (b == 0) cur_fwd = model ? model_decide() : 1'b0;
      send_beat(b == 0, (b % 8) == 7, {8'(fid), 8'(b)}, cur_fwd);
    end
    s_axi4s_tvalid = 1'b0;
    s_axi4s_tuser  = '0;
    s_axi4s_tlast  = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int pass, input int drop);
    checks++;
    if (stat_pass_count !== 16'(pass)) begin
      errors++;
      $display("FAIL %s_pass_count: got %0d required %0d", tag, stat_pass_count, pass);
    end
    checks++;
    if (stat_drop_count !== 16'(drop)) begin
      errors++;
      $display("FAIL %s_drop_count: got %0d required %0d", tag, stat_drop_count, drop);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (s_axi4s_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b required 1", s_axi4s_tready); end
    checks++;
    if (m_axi4s_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axi4s_tvalid); end
    checks++;
    if (stat_busy !== 1'b0 || stat_sof_error !== 1'b0) begin
      errors++; $display("FAIL rst_flags: busy=%b sof_err=%b required 0 0", stat_busy, stat_sof_error);
    end
    checks++;
    if (param_blank_num !== 8'd0) begin errors++; $display("FAIL rst_blank: got %0d required 0", param_blank_num); end
    check_stats("rst", 0, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_pass_all();
    for (int f = 0; f < 3; f++) send_frame(f, 0, BEATS, 1'b1);
    repeat (2) @(negedge aclk);
    check_stats("pass_all", 3, 0);
    checks++;
    if (param_blank_num !== 8'd5) begin errors++; $display("FAIL pass_all_blank: got %0d required 5", param_blank_num); end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_decimation();
    ctl_skip = 4'd2;
    for (int f = 0; f < 9; f++) send_frame(16 + f, 0, BEATS, 1'b1);
    repeat (2) @(negedge aclk);
    check_stats("decim", 6, 6);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_enable_mid();
    ctl_skip   = 4'd0;
    ctl_enable = 1'b0;
    @(posedge aclk);
    #1;
    send_frame(32, 0, 12, 1'b0);
    ctl_enable = 1'b1;
    send_frame(32, 12, BEATS, 1'b0);
    send_frame(33, 0, BEATS, 1'b1);
    repeat (2) @(negedge aclk);
    check_stats("en_mid", 7, 6);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_disable_mid();
    send_frame(40, 0, 12, 1'b1);
    ctl_enable = 1'b0;
    send_frame(40, 12, BEATS, 1'b1);
    repeat (2) @(negedge aclk);
    checks++;
    if (stat_busy !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b required 0", stat_busy); end
    @(posedge aclk);
    #1;
    send_frame(41, 0, BEATS, 1'b0);
    repeat (2) @(negedge aclk);
    check_stats("dis_mid", 8, 6);
    @(posedge aclk);
    #1;
    ctl_enable = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_early_sof();
    ctl_skip      = 4'd1;
    ctl_blank_num = 8'd7;
    send_frame(48, 0, 19, 1'b1);
    ctl_blank_num = 8'd9;
    repeat (2) @(negedge aclk);
    checks++;
    if (param_blank_num !== 8'd7) begin errors++; $display("FAIL early_blank_hold: got %0d required 7", param_blank_num); end
    checks++;
    if (stat_sof_error !== 1'b0 || stat_busy !== 1'b1) begin
      errors++; $display("FAIL early_pre: sof_err=%b busy=%b required 0 1", stat_sof_error, stat_busy);
    end
    @(posedge aclk);
    #1;
    send_frame(49, 0, BEATS, 1'b1);
    @(negedge aclk);
    checks++;
    if (stat_sof_error !== 1'b1) begin errors++; $display("FAIL early_sof_err: got %b required 1", stat_sof_error); end
    checks++;
    if (param_blank_num !== 8'd9) begin errors++; $display("FAIL early_blank_new: got %0d required 9", param_blank_num); end
    @(posedge aclk);
    #1;
    send_frame(50, 0, BEATS, 1'b1);
    send_frame(51, 0, BEATS, 1'b1);
    repeat (2) @(negedge aclk);
    check_stats("early", 10, 8);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_back_to_back_reset();
    ctl_skip = 4'd0;
    bp_en    = 1'b1;
    send_frame(56, 0, BEATS, 1'b1);
    send_frame(57, 0, BEATS, 1'b1);
    send_frame(58, 0, 14, 1'b1);
    bp_en = 1'b0;
    repeat (2) @(negedge aclk);
    check_stats("bp", 13, 8);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_stats("midrst", 0, 0);
    checks++;
    if (stat_sof_error !== 1'b0 || stat_busy !== 1'b0 || param_blank_num !== 8'd0) begin
      errors++;
      $display("FAIL midrst_state: sof_err=%b busy=%b blank=%0d required 0 0 0", stat_sof_error, stat_busy, param_blank_num);
    end
    checks++;
    if (s_axi4s_tready !== 1'b1 || m_axi4s_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_hs: tready=%b tvalid=%b required 1 0", s_axi4s_tready, m_axi4s_tvalid);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_phase = '0;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn        = 1'b0;
    ctl_enable     = 1'b1;
    ctl_skip       = 4'd0;
    ctl_blank_num  = 8'd5;
    s_axi4s_tuser  = '0;
    s_axi4s_tlast  = 1'b0;
    s_axi4s_tdata  = '0;
    s_axi4s_tvalid = 1'b0;
    test_reset();
    test_pass_all();
    test_decimation();
    test_enable_mid();
    test_disable_mid();
    test_early_sof();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
